// File: rtl/uart_rx_sequencer.sv
// Sequencer for the oversampling UART receiver: gates ENABLE, captures finished words
// into a show-ahead FIFO, clears the receiver after each frame and aborts stuck frames.
module uart_rx_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 80,
  parameter int CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          run,
  input  logic                          rx_line,
  input  logic                          rx_done,
  input  logic [7:0]                    rx_word,
  output logic                          rx_enable,
  output logic                          rx_cls_word,
  output logic                          rx_done_clr,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          timeout,
  input  logic                          flag_clr
);

  localparam int               AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] T_MAX = CNT_W'(TIMEOUT_CYC);
  localparam logic [AW:0]      DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, CLEAR} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer;
  logic             timer_idle, time_up, to_set;
  logic             push, pop, wr_ok, drop;
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [7:0]       mem [FIFO_DEPTH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= T_MAX) ? T_MAX : v + 1'b1;
  endfunction

  // A zero timer means no start bit has been seen yet in this ARM window.
  assign timer_idle = (timer == '0);
  assign time_up    = (timer == T_MAX);

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    rx_enable   = 1'b0;
    rx_cls_word = 1'b0;
    rx_done_clr = 1'b0;
    to_set      = 1'b0;
    case (state)
      IDLE: if (run) state_nxt = ARM;
      ARM: begin
        rx_enable = 1'b1;
        if (rx_done) state_nxt = CAPTURE;
        else if (time_up) begin
          state_nxt = CLEAR;
          to_set    = 1'b1;
        end else if (!run && timer_idle) state_nxt = IDLE;
      end
      CAPTURE: begin
        rx_enable   = 1'b1;
        rx_done_clr = 1'b1;
        state_nxt   = CLEAR;
      end
      CLEAR: begin
        rx_cls_word = 1'b1;
        state_nxt   = run ? ARM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res)                                           timer <= '0;
    else if (state != ARM)                              timer <= '0;
    else if (!timer_idle || !rx_line)                   timer <= sat_inc(timer);
  end

  // A push into a full FIFO only lands when a pop frees the head slot in the same cycle.
  assign push       = (state == CAPTURE);
  assign pop        = rd_en && !fifo_empty;
  assign wr_ok      = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;
  assign rd_ptr_nxt = rd_ptr + 1'b1;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == DEPTH);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= rx_word;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rd_data    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr_nxt;
      case ({wr_ok, pop})
        2'b10:   fifo_count <= fifo_count + ONE;
        2'b01:   fifo_count <= fifo_count - ONE;
        default: fifo_count <= fifo_count;
      endcase
      if (pop) begin
        if (fifo_count > ONE) rd_data <= mem[rd_ptr_nxt];
        else if (wr_ok)       rd_data <= rx_word;
      end else if (wr_ok && fifo_empty) begin
        rd_data <= rx_word;
      end
    end
  end

  // Setting a sticky flag wins over clearing it in the same cycle.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      overflow <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (drop)          overflow <= 1'b1;
      else if (flag_clr) overflow <= 1'b0;
      if (to_set)        timeout  <= 1'b1;
      else if (flag_clr) timeout  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer: a simple receiver model drives frames while
// FIFO contents, handshake pulses and sticky flags are compared to hand-derived values.
module tb_uart_rx_sequencer;

  logic       clk = 1'b0;
  logic       res, run, rx_line, rx_done, rd_en, flag_clr;
  logic [7:0] rx_word;
  logic       rx_enable, rx_cls_word, rx_done_clr;
  logic [7:0] rd_data;
  logic       fifo_empty, fifo_full, overflow, timeout;
  logic [2:0] fifo_count;

  int n_chk = 0;
  int n_err = 0;

  uart_rx_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYC(80), .CNT_W(8)) dut (
    .clk(clk), .res(res), .run(run), .rx_line(rx_line), .rx_done(rx_done),
    .rx_word(rx_word), .rx_enable(rx_enable), .rx_cls_word(rx_cls_word),
    .rx_done_clr(rx_done_clr), .rd_en(rd_en), .rd_data(rd_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .overflow(overflow), .timeout(timeout), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: start bit, a few sample cycles, then rx_done with the word held through CAPTURE.
  task automatic send(input logic [7:0] w, input logic pop_in_cap);
    rx_line = 1'b0;
    step();
    rx_line = 1'b1;
    step();
    step();
    rx_word = w;
    rx_done = 1'b1;
    step();
    check("done_clr_pulse", rx_done_clr, 1);
    check("enable_capture", rx_enable, 1);
    rx_done = 1'b0;
    rd_en   = pop_in_cap;
    step();
    rd_en = 1'b0;
    check("cls_word_pulse", rx_cls_word, 1);
    check("enable_clear", rx_enable, 0);
    check("done_clr_once", rx_done_clr, 0);
    step();
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    check(tag, rd_data, exp);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    res = 1'b0; run = 1'b0; rx_line = 1'b1; rx_done = 1'b0;
    rd_en = 1'b0; flag_clr = 1'b0; rx_word = 8'h00;
    step();
    step();
    check("rst_enable", rx_enable, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_count", fifo_count, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cls", rx_cls_word, 0);
    check("rst_done_clr", rx_done_clr, 0);
    res = 1'b1;
    step();
    check("idle_enable", rx_enable, 0);

    // single frame
    run = 1'b1;
    step();
    check("arm_enable", rx_enable, 1);
    send(8'hA5, 1'b0);
    check("t1_count", fifo_count, 1);
    check("t1_rd_data", rd_data, 8'hA5);
    check("t1_back_arm", rx_enable, 1);
    pop_chk("t1_pop", 8'hA5);
    check("t1_empty", fifo_empty, 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("pop_empty_count", fifo_count, 0);
    check("pop_empty_ovf", overflow, 0);

    // fill and overflow
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    check("t2_full", fifo_full, 1);
    check("t2_ovf_before", overflow, 0);
    send(8'h05, 1'b0);
    check("t2_overflow", overflow, 1);
    check("t2_count", fifo_count, 4);
    for (int i = 1; i <= 4; i++) pop_chk("t2_pop", 8'(i));
    check("t2_empty", fifo_empty, 1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check("t2_ovf_clr", overflow, 0);

    // push and pop together while full
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b0);
    send(8'h55, 1'b1);
    check("t3_count", fifo_count, 4);
    check("t3_overflow", overflow, 0);
    pop_chk("t3_pop0", 8'h12);
    pop_chk("t3_pop1", 8'h13);
    pop_chk("t3_pop2", 8'h14);
    pop_chk("t3_pop3", 8'h55);
    check("t3_empty", fifo_empty, 1);

    // stuck frame timeout; flag_clr in the setting cycle must lose
    rx_line = 1'b0;
    step();
    rx_line = 1'b1;
    repeat (79) step();
    check("t4_pre_timeout", timeout, 0);
    check("t4_pre_enable", rx_enable, 1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check("t4_timeout", timeout, 1);
    check("t4_enable_low", rx_enable, 0);
    check("t4_cls", rx_cls_word, 1);
    step();
    check("t4_rearm", rx_enable, 1);
    check("t4_sticky", timeout, 1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check("t4_clr", timeout, 0);

    // run dropped mid-frame
    rx_line = 1'b0;
    step();
    rx_line = 1'b1;
    run = 1'b0;
    step();
    check("t5_keep_arm", rx_enable, 1);
    rx_word = 8'h77;
    rx_done = 1'b1;
    step();
    check("t5_done_clr", rx_done_clr, 1);
    rx_done = 1'b0;
    step();
    check("t5_cls", rx_cls_word, 1);
    step();
    check("t5_idle", rx_enable, 0);
    check("t5_count", fifo_count, 1);
    check("t5_rd_data", rd_data, 8'h77);
    rx_done = 1'b1;
    step();
    check("t5_ignore_done", rx_done_clr, 0);
    check("t5_still_idle", rx_enable, 0);
    rx_done = 1'b0;
    run = 1'b1;
    step();
    check("t5_arm", rx_enable, 1);
    run = 1'b0;
    step();
    check("t5_idle_now", rx_enable, 0);

    // reset during CAPTURE
    run = 1'b1;
    step();
    rx_word = 8'h99;
    rx_done = 1'b1;
    step();
    check("t6_in_capture", rx_done_clr, 1);
    res = 1'b0;
    #1;
    check("t6_done_clr", rx_done_clr, 0);
    check("t6_enable", rx_enable, 0);
    check("t6_empty", fifo_empty, 1);
    check("t6_count", fifo_count, 0);
    check("t6_rd_data", rd_data, 0);
    rx_done = 1'b0;
    run = 1'b0;
    #2;
    res = 1'b1;
    step();
    check("t6_no_word", fifo_empty, 1);
    check("t6_idle", rx_enable, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
